// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU operation sequencer:
//   - default operand width and iteration counter width
//   - opcode encodings for the request channel
//   - FSM state encoding
//   - op_legal(): opcode legality check (110 and 111 are illegal)
// Optional feature macro used by the sequencer files: ALU_SEQ_MUL_EARLY_EXIT_EN
package alu_seq_pkg;

  localparam int WIDTH_DEF = 24;
  localparam int CNT_W_DEF = 5;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Opcodes 11x are reserved and reported as errors.
  function automatic logic op_legal(input logic [2:0] op);
    return !(op[2] & op[1]);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
// Request/response channel bundle between the execute stage and the sequencer.
//   request : req_valid, req_ready, req_op[2:0], req_a, req_b
//   response: rsp_valid, rsp_ready, rsp_result, rsp_carry, rsp_zero, rsp_err
// Modports:
//   master - the execute stage (issues requests, consumes responses)
//   slave  - the sequencer
interface alu_op_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu_seq_mul.sv
// alu_seq_mul
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          load a/b and begin a new product (one-cycle pulse)
//   a, b           multiplicand / multiplier, sampled on start
//   done           level, set after the final iteration, cleared by start
//   product        low WIDTH bits of a*b once done is high
// With ALU_SEQ_MUL_EARLY_EXIT_EN defined the run stops as soon as the
// remaining multiplier bits are all zero (always at least one iteration);
// otherwise exactly WIDTH iterations are performed.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] prod_r;
  logic [CNT_W-1:0] cnt_r;
  logic             run_r;
  logic             done_r;
  logic             last_s;

  // Decide whether the iteration in progress is the final one.
  always_comb begin
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
    // mplier_r[0] is consumed this cycle; stop if nothing remains above it.
    last_s = (cnt_r == LAST_CNT) || (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
    last_s = (cnt_r == LAST_CNT);
`endif
  end

  // Shift-add datapath and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      prod_r   <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      run_r    <= 1'b0;
      done_r   <= 1'b0;
    end else if (start) begin
      mcand_r  <= a;
      mplier_r <= b;
      prod_r   <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      run_r    <= 1'b1;
      done_r   <= 1'b0;
    end else if (run_r) begin
      if (mplier_r[0]) begin
        prod_r <= prod_r + mcand_r;
      end else begin
        prod_r <= prod_r;
      end
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CNT_W'(1);
      if (last_s) begin
        run_r  <= 1'b0;
        done_r <= 1'b1;
      end else begin
        run_r  <= 1'b1;
        done_r <= 1'b0;
      end
    end else begin
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      prod_r   <= prod_r;
      cnt_r    <= cnt_r;
      run_r    <= run_r;
      done_r   <= done_r;
    end
  end

  assign done    = done_r;
  assign product = prod_r;

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multi-cycle ALU front end. Accepts one operation at a time, computes
// single-cycle ops (AND/OR/ADD/SLT/XOR) in EXEC and MUL through the
// iterative alu_seq_mul datapath, then presents the result in DONE until
// the consumer takes it.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          alu_op_sequencer_if.slave request/response channels
//   alu_sel      select code routed to the result mux (000 in IDLE / illegal)
//   busy         high whenever the FSM is not IDLE
// Optional feature macro: ALU_SEQ_MUL_EARLY_EXIT_EN (forwarded to alu_seq_mul).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_op_sequencer_if.slave     bus,
  output logic [2:0]            alu_sel,
  output logic                  busy
);

  state_e           state_r;
  state_e           state_nxt_s;

  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             exec_ph_r;

  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic             zero_r;
  logic             err_r;

  logic             req_ready_r;
  logic             rsp_valid_r;
  logic             busy_r;
  logic [2:0]       alu_sel_r;

  logic             req_ready_nxt_s;
  logic             rsp_valid_nxt_s;
  logic             busy_nxt_s;
  logic [2:0]       alu_sel_nxt_s;

  logic             accept_s;
  logic             mul_start_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_prod_s;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_carry_s;
  logic             alu_err_s;

  assign accept_s    = bus.req_valid && req_ready_r;
  assign mul_start_s = accept_s && (bus.req_op == OP_MUL);

  alu_seq_mul #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .a       (bus.req_a),
    .b       (bus.req_b),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // State register plus registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      alu_sel_r   <= 3'b000;
    end else begin
      state_r     <= state_nxt_s;
      req_ready_r <= req_ready_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      busy_r      <= busy_nxt_s;
      alu_sel_r   <= alu_sel_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = (bus.req_op == OP_MUL) ? ST_MUL : ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      // EXEC spends one cycle computing and one cycle holding the result.
      ST_EXEC: begin
        if (exec_ph_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the outputs come straight from flops.
  always_comb begin
    req_ready_nxt_s = (state_nxt_s == ST_IDLE);
    rsp_valid_nxt_s = (state_nxt_s == ST_DONE);
    busy_nxt_s      = (state_nxt_s != ST_IDLE);
    alu_sel_nxt_s   = alu_sel_r;
    if (state_nxt_s == ST_IDLE) begin
      alu_sel_nxt_s = 3'b000;
    end else if (state_r == ST_IDLE) begin
      alu_sel_nxt_s = op_legal(bus.req_op) ? bus.req_op : 3'b000;
    end else begin
      alu_sel_nxt_s = alu_sel_r;
    end
  end

  // Single-cycle ALU on the captured operands.
  always_comb begin
    sum_s       = {1'b0, a_r} + {1'b0, b_r};
    alu_res_s   = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_err_s   = 1'b0;
    case (op_r)
      OP_AND: alu_res_s = a_r & b_r;
      OP_OR:  alu_res_s = a_r | b_r;
      OP_ADD: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
      end
      OP_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
      OP_XOR: alu_res_s = a_r ^ b_r;
      // The product comes from the multiplier, not from this path.
      OP_MUL: alu_res_s = {WIDTH{1'b0}};
      default: begin
        alu_res_s = {WIDTH{1'b0}};
        alu_err_s = 1'b1;
      end
    endcase
  end

  // Operand capture and result registers; results stay put through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= 3'b000;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      exec_ph_r <= 1'b0;
      res_r     <= {WIDTH{1'b0}};
      carry_r   <= 1'b0;
      zero_r    <= 1'b0;
      err_r     <= 1'b0;
    end else if (accept_s) begin
      op_r      <= bus.req_op;
      a_r       <= bus.req_a;
      b_r       <= bus.req_b;
      exec_ph_r <= 1'b0;
    end else if ((state_r == ST_EXEC) && !exec_ph_r) begin
      res_r     <= alu_res_s;
      carry_r   <= alu_carry_s;
      zero_r    <= (alu_res_s == {WIDTH{1'b0}});
      err_r     <= alu_err_s;
      exec_ph_r <= 1'b1;
    end else if ((state_r == ST_MUL) && mul_done_s) begin
      res_r     <= mul_prod_s;
      carry_r   <= 1'b0;
      zero_r    <= (mul_prod_s == {WIDTH{1'b0}});
      err_r     <= 1'b0;
    end else begin
      res_r     <= res_r;
      carry_r   <= carry_r;
      zero_r    <= zero_r;
      err_r     <= err_r;
      exec_ph_r <= exec_ph_r;
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = res_r;
  assign bus.rsp_carry  = carry_r;
  assign bus.rsp_zero   = zero_r;
  assign bus.rsp_err    = err_r;
  assign alu_sel        = alu_sel_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Directed and randomized stimulus for alu_op_sequencer, checked against a
// behavioural model of the operations and their latencies.
// Honors ALU_SEQ_MUL_EARLY_EXIT_EN for the expected MUL latency.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int W = 24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] alu_sel;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic         e;
    logic         z;
    logic         c;
    logic [W-1:0] r;
  } exp_t;

  alu_op_sequencer_if #(.WIDTH(W)) bus ();

  alu_op_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .alu_sel (alu_sel),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of each opcode, from plain integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint unsigned s;
    longint unsigned p;
    int sa;
    int sb;
    e = '0;
    s = longint'(a) + longint'(b);
    p = longint'(a) * longint'(b);
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    case (op)
      3'd0: e.r = a & b;
      3'd1: e.r = a | b;
      3'd2: begin
        e.r = W'(s % (64'd1 << W));
        e.c = (s >= (64'd1 << W));
      end
      3'd3: e.r = (sa < sb) ? W'(1) : W'(0);
      3'd4: e.r = W'(p % (64'd1 << W));
      3'd5: e.r = a ^ b;
      default: begin
        e.r = '0;
        e.e = 1'b1;
      end
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Cycles from accept edge to the first sample with rsp_valid high.
  function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] b);
    int n;
    n = W;
    if (op == 3'd4) begin
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
      n = 1;
      for (int i = 0; i < W; i++) begin
        if (b[i]) n = i + 1;
      end
`endif
      return n + 1;
    end
    return 2;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input string tag);
    exp_t e;
    int lat;
    logic [2:0] sel_e;
    e = model(op, a, b);
    sel_e = (op >= 3'd6) ? 3'd0 : op;
    @(negedge clk);
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    chk({tag, ".req_ready_idle"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble the request lines; the captured operation must not change.
    bus.req_valid = 1'b0;
    bus.req_op = 3'($urandom);
    bus.req_a = W'($urandom);
    bus.req_b = W'($urandom);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".req_ready_busy"}, 32'(bus.req_ready), 32'd0);
    chk({tag, ".alu_sel"}, 32'(alu_sel), 32'(sel_e));
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat(op, b)));
    for (int i = 0; i <= hold; i++) begin
      chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, ".result"}, 32'(bus.rsp_result), 32'(e.r));
      chk({tag, ".carry"}, 32'(bus.rsp_carry), 32'(e.c));
      chk({tag, ".zero"}, 32'(bus.rsp_zero), 32'(e.z));
      chk({tag, ".err"}, 32'(bus.rsp_err), 32'(e.e));
      chk({tag, ".sel_done"}, 32'(alu_sel), 32'(sel_e));
      chk({tag, ".req_ready_done"}, 32'(bus.req_ready), 32'd0);
      if (i < hold) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk({tag, ".post_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".post_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".post_busy"}, 32'(busy), 32'd0);
    chk({tag, ".post_sel"}, 32'(alu_sel), 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = 3'd0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.result", 32'(bus.rsp_result), 32'd0);
    chk("rst.carry", 32'(bus.rsp_carry), 32'd0);
    chk("rst.zero", 32'(bus.rsp_zero), 32'd0);
    chk("rst.err", 32'(bus.rsp_err), 32'd0);
    chk("rst.alu_sel", 32'(alu_sel), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd2, 24'hFFFFFF, 24'h000001, 0, "add_wrap");
    run_op(3'd3, 24'h800000, 24'h000001, 0, "slt_neg");
    run_op(3'd3, 24'h000001, 24'h800000, 0, "slt_pos");
    run_op(3'd4, 24'h001234, 24'h000100, 0, "mul_full");
    run_op(3'd4, 24'hABCDEF, 24'h000000, 0, "mul_b0");
    run_op(3'd4, 24'hABCDEF, 24'h000001, 0, "mul_b1");
    run_op(3'd4, 24'hFFFFFF, 24'hFFFFFF, 0, "mul_max");
    run_op(3'd5, 24'hAAAAAA, 24'h555555, 5, "xor_bp");
    run_op(3'd7, 24'h123456, 24'h654321, 0, "ill_7");
    run_op(3'd6, 24'hFFFFFF, 24'hFFFFFF, 1, "ill_6");
    run_op(3'd0, 24'hF0F0F0, 24'h0FF00F, 0, "and");
    run_op(3'd1, 24'h000000, 24'h000000, 0, "or_zero");

    // Reset in the middle of a MUL aborts it immediately.
    @(negedge clk);
    bus.req_op = 3'd4;
    bus.req_a = 24'd5;
    bus.req_b = 24'd7;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst.busy", 32'(busy), 32'd0);
    chk("mid_rst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst.alu_sel", 32'(alu_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd2, 24'd1, 24'd1, 0, "add_after_rst");

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
             int'($urandom_range(0, 2)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
